// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU-control decode merged with a registered execute stage
// and an iterative shift-add multiplier, for the multi-cycle MIPS datapath.
// Single-cycle ops complete on the accepting edge; MUL retires MUL_BITS
// multiplier bits per cycle and holds busy until it finishes.
module alu_exec_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic [3:0]       alu_sel
);

    localparam int unsigned STEPS = WIDTH / MUL_BITS;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100
    } op_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

    state_t           state;
    op_t              dec_op;
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] step_sum;
    logic [CW-1:0]    count;
    logic             illegal_q;

    // Decode ALUOp/opcode into an operation; unknown encodings fall to ADD and flag illegal
    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (opcode)
                    6'd0, 6'd5: dec_op = OP_ADD;
                    6'd1, 6'd6: dec_op = OP_SUB;
                    6'd2, 6'd7: dec_op = OP_MUL;
                    6'd3, 6'd8: dec_op = OP_AND;
                    6'd4, 6'd9: dec_op = OP_OR;
                    default: begin
                        dec_op      = OP_ADD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_op      = OP_ADD;
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Single-cycle datapath, evaluated on the live operands at the accepting edge
    always_comb begin
        alu_res = a + b;
        case (dec_op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            default: alu_res = a + b;
        endcase
    end

    // One multiply step: accumulate multiplicand times the low MUL_BITS of the multiplier
    always_comb begin
        step_sum = acc;
        for (int unsigned i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) begin
                step_sum = step_sum + (mcand << i);
            end
        end
    end

    assign busy = (state == MUL_RUN);

    // Control FSM: acceptance, single-cycle completion and iterative multiply
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            illegal_q <= 1'b0;
            done      <= 1'b0;
            alu_sel   <= '0;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        alu_sel   <= dec_op;
                        illegal_q <= dec_illegal;
                        if (dec_op == OP_MUL) begin
                            state  <= MUL_RUN;
                            acc    <= '0;
                            mcand  <= a;
                            mplier <= b;
                            count  <= '0;
                        end else begin
                            result  <= alu_res;
                            zero    <= (alu_res == '0);
                            illegal <= dec_illegal;
                            done    <= 1'b1;
                        end
                    end
                end
                MUL_RUN: begin
                    acc    <= step_sum;
                    mcand  <= mcand << MUL_BITS;
                    mplier <= mplier >> MUL_BITS;
                    count  <= count + 1'b1;
                    // Last step folds its partial product straight into result
                    if (count == LAST_STEP) begin
                        result  <= step_sum;
                        zero    <= (step_sum == '0);
                        illegal <= illegal_q;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (MUL_BITS=1 and MUL_BITS=4).
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [1:0]  ALUOp, ALUOp2;
    logic [5:0]  opcode, opcode2;
    logic [31:0] a, b, a2, b2;
    logic        busy, done, zero, illegal;
    logic        busy2, done2, zero2, illegal2;
    logic [31:0] result, result2;
    logic [3:0]  alu_sel, alu_sel2;

    int unsigned passed = 0;
    int unsigned total  = 0;

    alu_exec_unit #(.WIDTH(32), .MUL_BITS(1)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .opcode(opcode),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero),
        .illegal(illegal), .alu_sel(alu_sel)
    );

    alu_exec_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start2), .ALUOp(ALUOp2), .opcode(opcode2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .result(result2), .zero(zero2),
        .illegal(illegal2), .alu_sel(alu_sel2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present a request for one edge; returns in the cycle after acceptance
    task automatic issue(input logic [1:0] op, input logic [5:0] opc,
                         input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        start = 1'b1; ALUOp = op; opcode = opc; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int n;
        int busy_cnt;
        int pulses;
        bit got;

        reset = 1'b1; start = 1'b0; ALUOp = '0; opcode = '0; a = '0; b = '0;
        start2 = 1'b0; ALUOp2 = '0; opcode2 = '0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 32'h0);
        check("rst_zero", zero, 1);
        check("rst_illegal", illegal, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_sel", alu_sel, 0);
        reset = 1'b0;

        // ADD via funct decode
        issue(2'b10, 6'd0, 32'd5, 32'd7);
        check("add_done", done, 1);
        check("add_result", result, 32'd12);
        check("add_zero", zero, 0);
        check("add_illegal", illegal, 0);
        check("add_sel", alu_sel, 4'b0000);
        @(negedge clk);
        check("add_done_low", done, 0);
        check("add_hold", result, 32'd12);

        // SUB to zero, then SUB wraparound
        issue(2'b10, 6'd6, 32'd9, 32'd9);
        check("sub_result", result, 32'd0);
        check("sub_zero", zero, 1);
        check("sub_sel", alu_sel, 4'b0001);
        issue(2'b01, 6'd0, 32'd0, 32'd1);
        check("sub_wrap", result, 32'hFFFF_FFFF);
        check("sub_wrap_zero", zero, 0);

        // OR through the alternate opcode
        issue(2'b10, 6'd9, 32'h0000_00F0, 32'h0000_000F);
        check("or_result", result, 32'h0000_00FF);
        check("or_sel", alu_sel, 4'b0100);

        // MUL -3 * 7, with a start pulse while busy and operand churn
        @(negedge clk);
        start = 1'b1; ALUOp = 2'b10; opcode = 6'd7; a = 32'hFFFF_FFFD; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        check("mul_busy_e0", busy, 1);
        check("mul_done_e0", done, 0);
        check("mul_sel", alu_sel, 4'b0010);
        busy_cnt = 1; n = 0; got = 0;
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
            else begin
                busy_cnt += int'(busy);
                if (n == 5) begin
                    start = 1'b1; ALUOp = 2'b10; opcode = 6'd3; a = 32'hF0F0; b = 32'hFF00;
                end else if (n == 6) begin
                    start = 1'b0;
                end
            end
        end
        check("mul_done_seen", got, 1);
        check("mul_latency", n, 32);
        check("mul_busy_cycles", busy_cnt, 32);
        check("mul_result", result, 32'hFFFF_FFEB);
        check("mul_zero", zero, 0);
        check("mul_illegal", illegal, 0);
        check("mul_busy_end", busy, 0);
        check("mul_sel_kept", alu_sel, 4'b0010);

        // Back-to-back: AND accepted in the MUL done cycle
        start = 1'b1; ALUOp = 2'b10; opcode = 6'd3; a = 32'hF0F0; b = 32'hFF00;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_done", done, 1);
        check("b2b_result", result, 32'h0000_F000);
        check("b2b_sel", alu_sel, 4'b0011);
        check("b2b_busy", busy, 0);
        @(posedge clk); #1;
        check("b2b_done_low", done, 0);

        // Illegal decodes
        issue(2'b10, 6'd12, 32'd2, 32'd3);
        check("ill_result", result, 32'd5);
        check("ill_flag", illegal, 1);
        check("ill_sel", alu_sel, 4'b0000);
        issue(2'b11, 6'd1, 32'd4, 32'd4);
        check("ill11_result", result, 32'd8);
        check("ill11_flag", illegal, 1);
        issue(2'b00, 6'd33, 32'd1, 32'd1);
        check("legal_again", illegal, 0);
        check("legal_result", result, 32'd2);

        // Reset ten cycles into a MUL
        @(negedge clk);
        start = 1'b1; ALUOp = 2'b10; opcode = 6'd2; a = 32'd3; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_pre", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_result", result, 32'd0);
        check("abort_zero", zero, 1);
        check("abort_done", done, 0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            pulses += int'(done);
        end
        check("abort_no_done", pulses, 0);
        issue(2'b00, 6'd0, 32'd3, 32'd4);
        check("post_abort_done", done, 1);
        check("post_abort_result", result, 32'd7);

        // MUL_BITS=4 instance
        @(negedge clk);
        start2 = 1'b1; ALUOp2 = 2'b10; opcode2 = 6'd7; a2 = 32'hFFFF_FFFD; b2 = 32'd7;
        @(posedge clk); #1;
        start2 = 1'b0; a2 = '0; b2 = '0;
        check("mul4_busy", busy2, 1);
        n = 0; got = 0;
        while (n < 100 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done2) got = 1;
        end
        check("mul4_done_seen", got, 1);
        check("mul4_latency", n, 8);
        check("mul4_result", result2, 32'hFFFF_FFEB);
        check("mul4_busy_end", busy2, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
